// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front-end
//
// Purpose: common widths, the reset fetch address and the FIFO entry layout
//          used by fetch_queue and fetch_fifo.
// Ports:   none (package).
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Sequential next fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry instruction/PC buffer with flush
//
// Purpose: circular buffer of fetch_entry_t with read/write pointers and an
//          explicit entry count. Flush empties the buffer and wins over push/pop.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   flush             empty the buffer (pointers and count to 0)
//   push, push_data   write one entry at the tail
//   pop               retire the head entry
//   head              entry at the read pointer (valid when count != 0)
//   count             number of stored entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        // DEPTH is a power of two, so the pointer wraps by natural overflow.
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front-end: PC, BRAM issue, response buffering
//
// Purpose: owns the fetch PC, issues reads to a 1-cycle-latency instruction
//          BRAM and buffers returned instructions with their PCs ahead of the
//          IF/ID register. A decode redirect flushes the buffer, drops any
//          in-flight response and restarts fetch at the redirect target.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present a response directly
//          on the outputs when the buffer is empty (saves one cycle of latency).
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   redirect_valid, redirect_pc  decode redirect request and target
//   imem_en, imem_addr           BRAM read enable and word address
//   imem_rdata                   BRAM read data, valid the cycle after imem_en
//   out_valid, out_instr, out_pc instruction presented to IF/ID
//   out_ready                    IF/ID accepts the presented instruction
//   occupancy                    number of buffered entries
module fetch_queue #(
  parameter int                          DEPTH    = 4,
  parameter int                          XLEN     = fetch_pkg::XLEN,
  parameter int                          IADDR_W  = 14,
  parameter logic [fetch_pkg::XLEN-1:0]  RESET_PC = fetch_pkg::RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_en,
  output logic [IADDR_W-1:0]         imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            fifo_push;
  logic            fifo_pop;
  logic            pop;
  logic            issue;
  logic            bypass_hit;
  // Entries that will be committed after this edge: buffered + arriving - leaving.
  logic [CW:0]     demand;

`ifdef FETCH_QUEUE_BYPASS_EN
  // A response landing on an empty buffer is shown on the outputs this cycle.
  assign bypass_hit = inflight_q & (count == '0) & ~redirect_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    out_valid = (count != '0) | bypass_hit;
    out_pc    = bypass_hit ? inflight_pc_q : head.pc;
    out_instr = bypass_hit ? imem_rdata    : head.instr;

    // A redirect squashes the head, so it is never counted as consumed.
    pop       = out_valid & out_ready & ~redirect_valid;
    fifo_pop  = pop & ~bypass_hit;
    // A bypassed response that is accepted immediately never enters the buffer.
    fifo_push = inflight_q & ~redirect_valid & ~(bypass_hit & pop);
    push_data = '{pc: inflight_pc_q, instr: imem_rdata};
  end

  // Issue only if the response is guaranteed a free slot next cycle.
  assign demand = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue  = resetn & ~redirect_valid & (demand < (CW+1)'(DEPTH));

  always_comb begin
    imem_en   = resetn & (redirect_valid | issue);
    imem_addr = redirect_valid ? redirect_pc[IADDR_W+1:2] : fetch_pc_q[IADDR_W+1:2];
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_valid) begin
      // The redirect target is read this cycle, fetch continues after it.
      fetch_pc_d    = pc_next(redirect_pc);
      inflight_pc_d = redirect_pc;
      inflight_d    = 1'b1;
    end else if (issue) begin
      fetch_pc_d    = pc_next(fetch_pc_q);
      inflight_pc_d = fetch_pc_q;
      inflight_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .count     (count)
  );

  assign occupancy = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end for the pipelined RV64 core: owns the fetch PC, issues reads to the 1-cycle-latency instruction BRAM, and buffers returned instructions with their PCs in a small FIFO. It sits directly upstream of the IF/ID register, decoupling BRAM read latency and decode stalls from fetch. Decode-stage redirects (taken branch, JAL, JALR) flush the FIFO, discard any in-flight read, and restart fetch at the new PC.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- XLEN, 64: PC width.
- IADDR_W, 14: instruction BRAM word-address width; address is pc[IADDR_W+1:2].
- RESET_PC, 64'h0: first fetch address after reset.

- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- redirect_valid  in  1  decode redirect (PcSrc).
- redirect_pc  in  XLEN  redirect target.
- imem_en  out  1  BRAM read enable; high only on an issue cycle.
- imem_addr  out  IADDR_W  BRAM word address.
- imem_rdata  in  32  BRAM data, valid the cycle after an issue.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  XLEN  PC of out_instr.
- out_ready  in  1  IF/ID accepts (driven ~StallD).
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

## Operation
- State: fetch_pc, inflight flag plus inflight_pc, FIFO (rd_ptr, wr_ptr, count).
- Pop = out_valid & out_ready & ~redirect_valid.
- Issue when ~redirect_valid and count + inflight − pop < DEPTH: imem_en=1, imem_addr=fetch_pc[IADDR_W+1:2], inflight_pc←fetch_pc, fetch_pc←fetch_pc+4, inflight←1; otherwise inflight←0.
- Response: in the cycle after an issue (inflight=1), {inflight_pc, imem_rdata} is pushed at wr_ptr. Issue gating guarantees that a push never overflows.
- Redirect (highest priority): count, rd_ptr, and wr_ptr←0; any response arriving this cycle is dropped; imem_en=1 with imem_addr=redirect_pc[IADDR_W+1:2]; inflight←1, inflight_pc←redirect_pc; fetch_pc←redirect_pc+4. A pop in the same cycle is ignored.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Arithmetic: fetch_pc+4 wraps modulo 2^XLEN; imem_addr wraps modulo 2^IADDR_W; pointers wrap modulo DEPTH.
- Reset: out_valid=0, occupancy=0, imem_en=0 while resetn is low, fetch_pc=RESET_PC, inflight=0, pointers=0. The first cycle after deassertion issues RESET_PC. A reset asserted mid-operation discards all entries and the in-flight read immediately.

## Timing
- Issue→push: 1 cycle. out_valid rises 2 cycles after issue (1 cycle with bypass; see Configuration).
- out_valid = (count≠0). Outputs come from the FIFO head, are stable while out_ready=0, and carry no combinational path from imem_rdata (without bypass).
- imem_en depends combinationally on out_ready and redirect_valid.
- Steady state with out_ready=1 throughout: one instruction per cycle after initial fill.
- With out_ready held low, the FIFO fills to DEPTH and issue stops. No further imem_en occurs until a pop.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0 and a response arrives, out_valid=1 and the outputs are taken directly from {inflight_pc, imem_rdata} in that cycle. If popped in that cycle, the response is not written; otherwise it is pushed. Redirect→out_valid latency is 1 cycle.
- Undefined: no bypass. Responses always pass through the FIFO. Redirect→out_valid latency is 2 cycles.

## Structure
- Package fetch_pkg: XLEN, ILEN=32, RESET_PC default, and the fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo: DEPTH-entry storage with pointers and count, push/pop/flush ports. fetch_queue holds fetch_pc, issue gating, inflight tracking, and redirect priority.

## Test plan
- Reset release, out_ready=1, BRAM model with word n = n: out_pc sequence 0,4,8,… with out_instr 0,1,2…; the first out_valid occurs 2 cycles after reset release (1 cycle with bypass).
- out_ready=0 for 10 cycles: occupancy saturates at 4, and imem_en=0 once count+inflight=4. Raising out_ready then resumes in-order output with no loss or duplication.
- redirect_valid with redirect_pc=0x100 while 3 entries are buffered and a read is in flight: occupancy→0, the stale response is dropped, and the next out_pc is 0x100, then 0x104.
- Redirect in the same cycle as out_ready=1 with a valid head: the head is not counted as consumed, and the next accepted out_pc is the redirect target.
- Reset asserted mid-stream with DEPTH full: out_valid=0 immediately. After release, fetch restarts at RESET_PC.
- redirect_pc=0xFFFC with IADDR_W=14: imem_addr=0x3FFF, and the next issue has imem_addr=0x0000 with out_pc 0x10000.
